// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and default sizes for the iterative mul/div unit.
// No logic here, so there is no latency or backpressure.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_MULU = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_mag_core.sv
// Unsigned shift/subtract divider and shift/add multiplier sharing one {hi,lo} register.
// One step per cycle with step=1, a full op takes WIDTH steps; it has no backpressure and follows load/step.
module muldiv_mag_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             mode_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // Divide: lo holds the dividend and shifts quotient bits in from the right.
    // Multiply: lo holds the multiplier and the product shifts in from hi.
    always_comb begin
        sum  = '0;
        hi_n = hi;
        lo_n = lo;
        if (mode_q) begin
            sum = {1'b0, hi, lo[WIDTH-1]} - {2'b00, opnd_q};
            if (!sum[WIDTH+1]) begin
                {hi_n, lo_n} = {sum[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
            end else begin
                {hi_n, lo_n} = {hi[WIDTH-2:0], lo, 1'b0};
            end
        end else begin
            sum = {2'b00, hi} + {2'b00, opnd_q};
            if (lo[0]) begin
                {hi_n, lo_n} = {sum[WIDTH:0], lo[WIDTH-1:1]};
            end else begin
                {hi_n, lo_n} = {1'b0, hi, lo[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 1'b0;
            opnd_q <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (load) begin
            mode_q <= div_mode;
            hi     <= '0;
            lo     <= div_mode ? a_mag : b_mag;
            opnd_q <= div_mode ? b_mag : a_mag;
        end else if (step) begin
            hi <= hi_n;
            lo <= lo_n;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with sign fix-up, divide-by-zero handling and level-start rearm.
// busy is high for ITERS+1 cycles after a start; starts arriving while busy are dropped (no queueing).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH,
    parameter int ITERS = muldiv_pkg::ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_new,
    input  logic             div_start,
    input  logic             divu_start,
    input  logic             mul_start,
    input  logic             mulu_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div0
);

    localparam int CW = $clog2(ITERS);

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q, op_sel;
    logic             a_neg_q, b_neg_q, b_zero_q, armed;
    logic [WIDTH-1:0] a_raw_q;
    logic             mul_req, accept, sgn, load, step, fix, is_div;
    logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;

    assign mul_req = mul_start | mulu_start;
    assign accept  = (state == S_IDLE) && (div_start || divu_start || (mul_req && armed));

    always_comb begin
        if (div_start)       op_sel = OP_DIV;
        else if (divu_start) op_sel = OP_DIVU;
        else if (mul_start)  op_sel = OP_MUL;
        else                 op_sel = OP_MULU;
    end

    assign sgn   = (op_sel == OP_DIV) || (op_sel == OP_MUL);
    assign a_mag = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_mag = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_RUN;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == CW'(ITERS - 1)) state_n = S_FIX;
            end
            S_FIX: begin
                fix     = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    muldiv_mag_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .div_mode (!op_sel[1]),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .hi       (core_hi),
        .lo       (core_lo)
    );

    // a_neg_q/b_neg_q are only set for signed ops, so unsigned results pass through untouched.
    assign is_div = !op_q[1];
    assign prod   = (a_neg_q ^ b_neg_q) ? -{core_hi, core_lo} : {core_hi, core_lo};

    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (b_zero_q) begin
                fix_hi = a_raw_q;
                fix_lo = '1;
            end else begin
                fix_hi = a_neg_q ? -core_hi : core_hi;
                fix_lo = (a_neg_q ^ b_neg_q) ? -core_lo : core_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            res_hi   <= '0;
            res_lo   <= '0;
            div0     <= 1'b0;
            armed    <= 1'b1;
            cnt      <= '0;
            op_q     <= OP_DIV;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= '0;
        end else begin
            if (load) begin
                busy     <= 1'b1;
                cnt      <= '0;
                div0     <= 1'b0;
                op_q     <= op_sel;
                a_neg_q  <= sgn & op_a[WIDTH-1];
                b_neg_q  <= sgn & op_b[WIDTH-1];
                b_zero_q <= (op_b == '0);
                a_raw_q  <= op_a;
            end
            if (step) cnt <= cnt + CW'(1);
            if (fix) begin
                busy   <= 1'b0;
                res_hi <= fix_hi;
                res_lo <= fix_lo;
                div0   <= is_div & b_zero_q;
            end
            // A held mul level must not relaunch after completion; only a new instruction or a dropped level rearms.
            if (load && op_sel[1])            armed <= 1'b0;
            else if (instr_new || !mul_req)   armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model checked every cycle plus directed literal checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_new = 1'b0;
    logic        div_start = 1'b0, divu_start = 1'b0, mul_start = 1'b0, mulu_start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, div0;
    logic [31:0] res_hi, res_lo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    muldiv_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instr_new  (instr_new),
        .div_start  (div_start),
        .divu_start (divu_start),
        .mul_start  (mul_start),
        .mulu_start (mulu_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .res_hi     (res_hi),
        .res_lo     (res_lo),
        .div0       (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from integer arithmetic.
    task automatic compute(input int op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output logic d0);
        logic signed [31:0] sa, sb;
        logic signed [63:0] pa, pb;
        logic [63:0] p;
        sa = a; sb = b; pa = sa; pb = sb;
        d0 = 1'b0;
        hi = '0; lo = '0;
        if (op < 2 && b == 32'd0) begin
            hi = a; lo = 32'hFFFF_FFFF; d0 = 1'b1;
        end else if (op == 0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000; hi = 32'd0;
            end else begin
                lo = sa / sb; hi = sa % sb;
            end
        end else if (op == 1) begin
            lo = a / b; hi = a % b;
        end else begin
            if (op == 2) p = pa * pb;
            else         p = {32'd0, a} * {32'd0, b};
            hi = p[63:32]; lo = p[31:0];
        end
    endtask

    int          m_cnt = 0;
    int          m_op = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_div0 = 1'b0, p_div0 = 1'b0, m_armed = 1'b1, m_acc = 1'b0, m_req = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_hi = '0; m_lo = '0; m_div0 = 1'b0; m_armed = 1'b1;
        end else begin
            m_req = mul_start | mulu_start;
            m_acc = 1'b0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_div0 = p_div0;
                end
            end else begin
                m_acc = 1'b1;
                if (div_start)               m_op = 0;
                else if (divu_start)         m_op = 1;
                else if (m_req && m_armed)   m_op = mul_start ? 2 : 3;
                else                         m_acc = 1'b0;
                if (m_acc) begin
                    compute(m_op, op_a, op_b, p_hi, p_lo, p_div0);
                    m_cnt  = 33;
                    m_div0 = 1'b0;
                end
            end
            if (m_acc && m_op >= 2)          m_armed = 1'b0;
            else if (instr_new || !m_req)    m_armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_model", busy, m_cnt != 0);
            check("res_hi_model", res_hi, m_hi);
            check("res_lo_model", res_lo, m_lo);
            check("div0_model", div0, m_div0);
        end
    end

    int   rises = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (busy && !busy_prev) rises++;
        busy_prev = busy;
    end

    task automatic pulse(input int which, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        op_a = a; op_b = b;
        if (which == 0) div_start = 1'b1; else divu_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0; divu_start = 1'b0;
    endtask

    // Returns the number of cycles busy was high; leaves time at the first negedge with busy low.
    task automatic wait_op(output int cyc);
        bit seen;
        seen = 0;
        cyc  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin seen = 1; break; end
        end
        check("busy_rise_seen", seen, 1);
        if (seen) begin
            cyc = 1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (!busy) break;
                cyc++;
            end
        end
    endtask

    initial begin
        int cyc;
        int r0;
        #3 rst = 1'b0;
        #20;
        check("rst_busy", busy, 0);
        check("rst_hi", res_hi, 0);
        check("rst_lo", res_lo, 0);
        check("rst_div0", div0, 0);
        rst = 1'b1;
        chk_en = 1;

        pulse(1, 32'd100, 32'd7);
        wait_op(cyc);
        check("divu_latency", cyc, 33);
        check("divu_lo", res_lo, 14);
        check("divu_hi", res_hi, 2);
        check("divu_div0", div0, 0);
        check("model_divu_lo", m_lo, 14);

        pulse(0, 32'hFFFF_FFF9, 32'd2);
        wait_op(cyc);
        check("div_neg_lo", res_lo, 32'hFFFF_FFFD);
        check("div_neg_hi", res_hi, 32'hFFFF_FFFF);
        check("model_div_neg_hi", m_hi, 32'hFFFF_FFFF);

        pulse(0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_op(cyc);
        check("div_ovf_lo", res_lo, 32'h8000_0000);
        check("div_ovf_hi", res_hi, 0);
        check("div_ovf_div0", div0, 0);

        r0 = rises;
        @(posedge clk); #1;
        op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; mulu_start = 1'b1;
        repeat (40) @(posedge clk);
        #1 mulu_start = 1'b0;
        repeat (5) @(negedge clk);
        check("mulu_one_run", rises - r0, 1);
        check("mulu_idle_after", busy, 0);
        check("mulu_hi", res_hi, 32'hFFFF_FFFE);
        check("mulu_lo", res_lo, 32'h0000_0001);
        check("model_mulu_hi", m_hi, 32'hFFFF_FFFE);

        @(posedge clk); #1;
        op_a = 32'hFFFF_FFFD; op_b = 32'd5; mul_start = 1'b1;
        wait_op(cyc);
        check("mul_latency", cyc, 33);
        check("mul_hi", res_hi, 32'hFFFF_FFFF);
        check("mul_lo", res_lo, 32'hFFFF_FFF1);
        repeat (3) @(negedge clk);
        check("mul_no_relaunch", busy, 0);
        @(posedge clk); #1;
        op_a = 32'd6; op_b = 32'd7; instr_new = 1'b1;
        @(posedge clk); #1;
        instr_new = 1'b0;
        wait_op(cyc);
        check("mul2_latency", cyc, 33);
        check("mul2_hi", res_hi, 0);
        check("mul2_lo", res_lo, 42);
        @(posedge clk); #1 mul_start = 1'b0;

        pulse(1, 32'd5, 32'd0);
        fork
            wait_op(cyc);
            begin
                repeat (5) @(posedge clk);
                #1 divu_start = 1'b1; op_a = 32'd9; op_b = 32'd3;
                @(posedge clk);
                #1 divu_start = 1'b0;
            end
        join
        check("div0_latency", cyc, 33);
        check("div0_lo", res_lo, 32'hFFFF_FFFF);
        check("div0_hi", res_hi, 5);
        check("div0_flag", div0, 1);
        repeat (2) @(negedge clk);
        check("div0_ignored_start", busy, 0);

        pulse(1, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", res_hi, 0);
        check("arst_lo", res_lo, 0);
        check("arst_div0", div0, 0);
        @(posedge clk); #1 rst = 1'b1;

        pulse(1, 32'd100, 32'd7);
        wait_op(cyc);
        check("post_rst_latency", cyc, 33);
        check("post_rst_lo", res_lo, 14);
        check("post_rst_hi", res_hi, 2);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
